// File: rtl/jk_fsm_bank_pkg.sv
// Shared types and helpers for the jk_fsm_bank channel array.
package jk_fsm_bank_pkg;

  typedef enum logic {ST_OFF = 1'b0, ST_ON = 1'b1} jk_state_t;

  // Widest channel vector the popcount helper accepts.
  localparam int unsigned PC_MAX = 256;

  // Number of set bits in v; callers zero-extend narrower vectors.
  function automatic int unsigned popcount(input logic [PC_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < PC_MAX; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/jk_fsm_chan.sv
// One JK on/off channel: Moore state, minimum-dwell lockout, edge pulses and,
// with JK_FSM_BANK_STATS_EN defined, a saturating OFF->ON transition counter.
module jk_fsm_chan
  import jk_fsm_bank_pkg::*;
#(
  parameter int unsigned MIN_DWELL   = 0,
  parameter int unsigned TOGGLE_MODE = 0
`ifdef JK_FSM_BANK_STATS_EN
  ,
  parameter int unsigned STAT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              en,
  input  logic              j,
  input  logic              k,
`ifdef JK_FSM_BANK_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_cnt,
`endif
  output logic              out,
  output logic              rise,
  output logic              fall
);

  localparam int unsigned DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

  jk_state_t     state;
  logic [DW-1:0] dwell;
  logic          go;

  // Decide whether this channel leaves its current state on the next enabled edge.
  always_comb begin
    go = 1'b0;
    if (dwell == '0) begin
      if ((TOGGLE_MODE != 0) && j && k) begin
        go = 1'b1;
      end else begin
        unique case (state)
          ST_OFF:  go = j;
          ST_ON:   go = k;
          default: go = 1'b0;
        endcase
      end
    end
  end

  // State, dwell lockout and one-cycle edge pulses; pulses drop even when frozen.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= ST_OFF;
      dwell <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        if (go) begin
          state <= (state == ST_OFF) ? ST_ON : ST_OFF;
          dwell <= DW'(MIN_DWELL);
          rise  <= (state == ST_OFF);
          fall  <= (state == ST_ON);
        end else if (dwell != '0) begin
          dwell <= dwell - DW'(1);
        end
      end
    end
  end

  assign out = (state == ST_ON);

`ifdef JK_FSM_BANK_STATS_EN
  logic [STAT_W-1:0] cnt;

  // Saturating OFF->ON counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (stat_clr) begin
      cnt <= '0;
    end else if (en && go && (state == ST_OFF) && (cnt != '1)) begin
      cnt <= cnt + STAT_W'(1);
    end
  end

  assign stat_cnt = cnt;
`endif

endmodule

// File: rtl/jk_fsm_bank.sv
// Bank of NUM_CH independent JK on/off channels with dwell lockout, edge
// pulses and popcount. Define JK_FSM_BANK_STATS_EN to add per-channel
// OFF->ON transition counters readable through stat_sel/stat_cnt.
module jk_fsm_bank
  import jk_fsm_bank_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MIN_DWELL   = 0,
  parameter int unsigned TOGGLE_MODE = 0,
  parameter int unsigned STAT_W      = 16
) (
  input  logic                                        clk,
  input  logic                                        areset,
  input  logic                                        en,
  input  logic [NUM_CH-1:0]                           j,
  input  logic [NUM_CH-1:0]                           k,
  output logic [NUM_CH-1:0]                           out,
  output logic [NUM_CH-1:0]                           rise,
  output logic [NUM_CH-1:0]                           fall,
  output logic [$clog2(NUM_CH+1)-1:0]                 on_count,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] stat_sel,
  input  logic                                        stat_clr,
  output logic [STAT_W-1:0]                           stat_cnt
);

  localparam int unsigned CW = $clog2(NUM_CH + 1);
  localparam int unsigned SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef JK_FSM_BANK_STATS_EN
  logic [STAT_W-1:0] chan_cnt [NUM_CH];
`endif

  // One channel instance per bit of j/k.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    jk_fsm_chan #(
      .MIN_DWELL   (MIN_DWELL),
      .TOGGLE_MODE (TOGGLE_MODE)
`ifdef JK_FSM_BANK_STATS_EN
      ,
      .STAT_W      (STAT_W)
`endif
    ) u_chan (
      .clk      (clk),
      .areset   (areset),
      .en       (en),
      .j        (j[i]),
      .k        (k[i]),
`ifdef JK_FSM_BANK_STATS_EN
      .stat_clr (stat_clr),
      .stat_cnt (chan_cnt[i]),
`endif
      .out      (out[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  // Popcount of the registered channel states (NUM_CH must not exceed PC_MAX).
  assign on_count = CW'(popcount(PC_MAX'(out)));

`ifdef JK_FSM_BANK_STATS_EN
  // Stats read mux; selects beyond the last channel read as zero.
  always_comb begin
    stat_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (SW'(i) == stat_sel) stat_cnt = chan_cnt[i];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{stat_sel, stat_clr};
  assign stat_cnt     = '0;
`endif

endmodule

// File: tb/tb_jk_fsm_bank.sv
// Directed self-checking bench for jk_fsm_bank; several instances with
// different parameters share one stimulus bus.
module tb_jk_fsm_bank;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       en = 1'b1;
  logic [3:0] j = '0;
  logic [3:0] k = '0;
  logic [1:0] stat_sel = '0;
  logic [2:0] ss_sel = 3'd1;
  logic       stat_clr = 1'b0;

  logic [3:0]  out_c, rise_c, fall_c;  logic [2:0] cnt_c; logic [15:0] sc_c;
  logic [3:0]  out_t, rise_t, fall_t;  logic [2:0] cnt_t; logic [15:0] sc_t;
  logic [3:0]  out_3, rise_3, fall_3;  logic [2:0] cnt_3; logic [15:0] sc_3;
  logic [3:0]  out_5, rise_5, fall_5;  logic [2:0] cnt_5; logic [15:0] sc_5;
  logic [4:0]  out_s, rise_s, fall_s;  logic [2:0] cnt_s; logic [1:0]  sc_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  jk_fsm_bank #(.NUM_CH(4), .MIN_DWELL(0), .TOGGLE_MODE(0)) u_c (
    .clk(clk), .areset(areset), .en(en), .j(j), .k(k), .out(out_c), .rise(rise_c),
    .fall(fall_c), .on_count(cnt_c), .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(sc_c));
  jk_fsm_bank #(.NUM_CH(4), .MIN_DWELL(0), .TOGGLE_MODE(1)) u_t (
    .clk(clk), .areset(areset), .en(en), .j(j), .k(k), .out(out_t), .rise(rise_t),
    .fall(fall_t), .on_count(cnt_t), .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(sc_t));
  jk_fsm_bank #(.NUM_CH(4), .MIN_DWELL(3), .TOGGLE_MODE(0)) u_d3 (
    .clk(clk), .areset(areset), .en(en), .j(j), .k(k), .out(out_3), .rise(rise_3),
    .fall(fall_3), .on_count(cnt_3), .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(sc_3));
  jk_fsm_bank #(.NUM_CH(4), .MIN_DWELL(5), .TOGGLE_MODE(0)) u_d5 (
    .clk(clk), .areset(areset), .en(en), .j(j), .k(k), .out(out_5), .rise(rise_5),
    .fall(fall_5), .on_count(cnt_5), .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(sc_5));
  jk_fsm_bank #(.NUM_CH(5), .MIN_DWELL(0), .TOGGLE_MODE(0), .STAT_W(2)) u_s (
    .clk(clk), .areset(areset), .en(en), .j({1'b0, j}), .k({1'b0, k}), .out(out_s),
    .rise(rise_s), .fall(fall_s), .on_count(cnt_s), .stat_sel(ss_sel), .stat_clr(stat_clr),
    .stat_cnt(sc_s));

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #1;
    areset = 1'b1;
    en = 1'b1; j = '0; k = '0; stat_clr = 1'b0; stat_sel = '0; ss_sel = 3'd1;
    #2;
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    j = 4'b1111;
    step();
    j = '0;
    total_cnt++;
    if (out_c !== 4'b1111 || cnt_c !== 3'd4) $display("FAIL reset_pre out=%b cnt=%0d exp out=1111 cnt=4", out_c, cnt_c);
    else pass_cnt++;
    areset = 1'b1;
    #1;
    total_cnt++;
    if (out_c !== 4'b0000 || cnt_c !== 3'd0 || rise_c !== 4'b0000 || out_3 !== 4'b0000)
      $display("FAIL reset_async out=%b cnt=%0d rise=%b out_d3=%b exp all zero", out_c, cnt_c, rise_c, out_3);
    else pass_cnt++;
    #1;
    areset = 1'b0;
  endtask

  task automatic test_classic();
    do_reset();
    j = 4'b0001;
    step();
    j = '0;
    total_cnt++;
    if (out_c !== 4'b0001 || rise_c !== 4'b0001 || fall_c !== 4'b0000 || cnt_c !== 3'd1)
      $display("FAIL classic_on out=%b rise=%b fall=%b cnt=%0d exp 0001/0001/0000/1", out_c, rise_c, fall_c, cnt_c);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_c !== 4'b0001 || rise_c !== 4'b0000) $display("FAIL classic_rise_clr out=%b rise=%b exp 0001/0000", out_c, rise_c);
    else pass_cnt++;
    k = 4'b0001;
    step();
    k = '0;
    total_cnt++;
    if (out_c !== 4'b0000 || fall_c !== 4'b0001 || rise_c !== 4'b0000)
      $display("FAIL classic_off out=%b fall=%b rise=%b exp 0000/0001/0000", out_c, fall_c, rise_c);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fall_c !== 4'b0000) $display("FAIL classic_fall_clr fall=%b exp 0000", fall_c);
    else pass_cnt++;
  endtask

  task automatic test_both_jk();
    logic [3:0] exp_o;
    do_reset();
    j = 4'b1111;
    k = 4'b1111;
    for (int c = 1; c <= 4; c++) begin
      step();
      exp_o = (c % 2 == 1) ? 4'b1111 : 4'b0000;
      total_cnt++;
      if (out_c !== exp_o || out_t !== exp_o || rise_c !== exp_o || fall_c !== ~exp_o || rise_t !== exp_o)
        $display("FAIL both_jk_c%0d out=%b out_t=%b rise=%b fall=%b exp out=%b", c, out_c, out_t, rise_c, fall_c, exp_o);
      else pass_cnt++;
    end
    j = '0;
    k = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    j = 4'b0101;
    step();
    total_cnt++;
    if (out_c !== 4'b0101 || cnt_c !== 3'd2) $display("FAIL simul_set out=%b cnt=%0d exp 0101/2", out_c, cnt_c);
    else pass_cnt++;
    j = 4'b1010;
    k = 4'b0101;
    step();
    j = '0;
    k = '0;
    total_cnt++;
    if (out_c !== 4'b1010 || cnt_c !== 3'd2 || rise_c !== 4'b1010 || fall_c !== 4'b0101)
      $display("FAIL simul_swap out=%b cnt=%0d rise=%b fall=%b exp 1010/2/1010/0101", out_c, cnt_c, rise_c, fall_c);
    else pass_cnt++;
  endtask

  task automatic test_dwell();
    do_reset();
    j = 4'b0001;
    step();
    j = '0;
    total_cnt++;
    if (out_3 !== 4'b0001 || rise_3 !== 4'b0001) $display("FAIL dwell_on out=%b rise=%b exp 0001/0001", out_3, rise_3);
    else pass_cnt++;
    k = 4'b0001;
    for (int c = 2; c <= 4; c++) begin
      step();
      total_cnt++;
      if (out_3 !== 4'b0001) $display("FAIL dwell_hold_c%0d out=%b exp 0001", c, out_3);
      else pass_cnt++;
    end
    step();
    k = '0;
    total_cnt++;
    if (out_3 !== 4'b0000 || fall_3 !== 4'b0001) $display("FAIL dwell_release out=%b fall=%b exp 0000/0001", out_3, fall_3);
    else pass_cnt++;
    // A single k pulse that lands inside the lockout is dropped.
    do_reset();
    j = 4'b0001;
    step();
    j = '0;
    step();
    k = 4'b0001;
    step();
    k = '0;
    total_cnt++;
    if (out_c !== 4'b0000 || out_3 !== 4'b0001) $display("FAIL dwell_pulse out_c=%b out_d3=%b exp 0000/0001", out_c, out_3);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) step();
    total_cnt++;
    if (out_3 !== 4'b0001) $display("FAIL dwell_no_queue out=%b exp 0001", out_3);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    logic [1:0] sc_before;
    do_reset();
    j = 4'b0001;
    step();
    sc_before = sc_s;
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      j = 4'($urandom);
      k = 4'($urandom);
      step();
      total_cnt++;
      if (out_3 !== 4'b0001 || out_c !== 4'b0001 || rise_3 !== 4'b0000 || fall_3 !== 4'b0000 ||
          rise_c !== 4'b0000 || fall_c !== 4'b0000 || sc_s !== sc_before)
        $display("FAIL freeze_c%0d out_d3=%b out_c=%b rise=%b fall=%b stat=%0d exp 0001/0001/0000/0000/%0d",
                 c, out_3, out_c, rise_3, fall_3, sc_s, sc_before);
      else pass_cnt++;
    end
    en = 1'b1;
    j = '0;
    k = 4'b0001;
    for (int c = 0; c < 3; c++) step();
    total_cnt++;
    if (out_3 !== 4'b0001) $display("FAIL freeze_residual out=%b exp 0001", out_3);
    else pass_cnt++;
    step();
    k = '0;
    total_cnt++;
    if (out_3 !== 4'b0000) $display("FAIL freeze_resume out=%b exp 0000", out_3);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    j = 4'b0100;
    step();
    j = '0;
    step();
    total_cnt++;
    if (out_5 !== 4'b0100) $display("FAIL rmd_on out=%b exp 0100", out_5);
    else pass_cnt++;
    areset = 1'b1;
    #1;
    total_cnt++;
    if (out_5 !== 4'b0000 || cnt_5 !== 3'd0) $display("FAIL rmd_async out=%b cnt=%0d exp 0000/0", out_5, cnt_5);
    else pass_cnt++;
    #1;
    areset = 1'b0;
    j = 4'b0100;
    step();
    j = '0;
    total_cnt++;
    if (out_5 !== 4'b0100 || rise_5 !== 4'b0100) $display("FAIL rmd_no_block out=%b rise=%b exp 0100/0100", out_5, rise_5);
    else pass_cnt++;
  endtask

  task automatic test_stats();
    logic [1:0] exp_s;
    do_reset();
`ifdef JK_FSM_BANK_STATS_EN
    total_cnt++;
    if (sc_s !== 2'd0) $display("FAIL stats_reset got=%0d exp 0", sc_s);
    else pass_cnt++;
    for (int n = 1; n <= 5; n++) begin
      j = 4'b0010;
      step();
      j = '0;
      k = 4'b0010;
      step();
      k = '0;
      exp_s = (n >= 3) ? 2'd3 : 2'(n);
      total_cnt++;
      if (sc_s !== exp_s) $display("FAIL stats_count_n%0d got=%0d exp %0d", n, sc_s, exp_s);
      else pass_cnt++;
    end
    j = 4'b0010;
    stat_clr = 1'b1;
    step();
    j = '0;
    stat_clr = 1'b0;
    total_cnt++;
    if (sc_s !== 2'd0 || out_s !== 5'b00010) $display("FAIL stats_clr_wins got=%0d out=%b exp 0/00010", sc_s, out_s);
    else pass_cnt++;
    k = 4'b0010;
    step();
    k = '0;
    j = 4'b0010;
    step();
    j = '0;
    total_cnt++;
    if (sc_s !== 2'd1) $display("FAIL stats_after_clr got=%0d exp 1", sc_s);
    else pass_cnt++;
    ss_sel = 3'd7;
    #1;
    total_cnt++;
    if (sc_s !== 2'd0) $display("FAIL stats_sel7 got=%0d exp 0", sc_s);
    else pass_cnt++;
    ss_sel = 3'd0;
    #1;
    total_cnt++;
    if (sc_s !== 2'd0) $display("FAIL stats_sel0 got=%0d exp 0", sc_s);
    else pass_cnt++;
    ss_sel = 3'd1;
`else
    exp_s = 2'd0;
    stat_sel = 2'd1;
    j = 4'b0010;
    step();
    j = '0;
    total_cnt++;
    if (sc_s !== exp_s || sc_c !== 16'd0 || out_s !== 5'b00010)
      $display("FAIL stats_tied got=%0d/%0d out=%b exp 0/0/00010", sc_s, sc_c, out_s);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_classic();
    test_both_jk();
    test_simultaneous();
    test_dwell();
    test_freeze();
    test_reset_mid_dwell();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jk_fsm_bank.md
Name: jk_fsm_bank

Overview:
- Parametrised multi-channel successor to the team's single 2-state JK on/off FSM.
- NUM_CH independent Moore FSMs (OFF/ON), each driven by its own j/k bit.
- Adds a minimum-dwell lockout per channel, an optional toggle-on-j&k mode, global freeze, edge pulses and a population count.
- Sits in control/status paths where many latched enables must be debounced against rapid re-triggering.

Parameters:
NUM_CH, 4, number of channels (>=1)
MIN_DWELL, 0, cycles a channel must stay in a state before it may leave it (0 = immediate, classic behaviour)
TOGGLE_MODE, 0, 1: j&k both high flips state; 0: OFF looks only at j, ON looks only at k
STAT_W, 16, width of optional per-channel transition counters

Ports:
clk  in  1  clock, rising edge
areset  in  1  reset, asynchronous, active-high
en  in  1  global enable; low freezes all state, dwell counters and stats
j  in  NUM_CH  per-channel set request
k  in  NUM_CH  per-channel clear request
out  out  NUM_CH  1 = channel in ON
rise  out  NUM_CH  registered 1-cycle pulse, high in the first cycle out[i] is 1
fall  out  NUM_CH  registered 1-cycle pulse, high in the first cycle out[i] is 0 after ON
on_count  out  $clog2(NUM_CH+1)  combinational popcount of out
stat_sel  in  $clog2(NUM_CH) (min 1)  channel select for stats read
stat_clr  in  1  synchronous clear of all stats counters
stat_cnt  out  STAT_W  OFF->ON transition count of channel stat_sel

Behaviour:
- areset high, async: all channels OFF, dwell counters 0, rise = fall = 0, stats 0. out = 0 and on_count = 0 immediately. Reset mid-dwell discards the remaining dwell.
- Per channel i, next-state function when en=1 and dwell[i]==0:
  - OFF: goes to ON if j[i]; otherwise stays OFF. k is ignored.
  - ON: goes to OFF if k[i]; otherwise stays ON. j is ignored.
  - With TOGGLE_MODE=1, j&k=11 flips state in both OFF and ON. With TOGGLE_MODE=0 the two rules above already cover 11.
- Dwell counter:
  - Width $clog2(MIN_DWELL+1), min 1.
  - On any transition, loads MIN_DWELL. Otherwise decrements each en cycle while nonzero.
  - While dwell[i]!=0, state[i] holds regardless of j/k. Requests are not queued.
  - The first transition after reset is never blocked. With MIN_DWELL=0 the counter is always 0.
- Timing:
  - State updates at posedge clk, so out changes 1 cycle after the qualifying j/k sample.
  - rise/fall are registered together with the state, so they are aligned with the out edge.
  - rise/fall clear on the next clk even if en=0.
- en=0: state, dwell and stats hold. rise/fall forced to 0 at the next edge.
- Channels are fully independent. Simultaneous transitions on multiple channels are legal.
- on_count is a purely combinational popcount of registered out; no latency beyond out.

Optional Feature:
- Macro JK_FSM_BANK_STATS_EN.
- Defined:
  - Per-channel STAT_W counter increments on each OFF->ON transition and saturates at all-ones.
  - stat_clr=1 zeroes all counters at the next edge and wins over a same-cycle increment.
  - stat_cnt = counter[stat_sel] combinationally. stat_sel >= NUM_CH reads 0.
- Undefined: no counter storage; stat_cnt tied to 0; stat_sel and stat_clr ignored. Port list is identical in both builds.

Decomposition:
- Package jk_fsm_bank_pkg holds:
  - typedef enum logic {ST_OFF=1'b0, ST_ON=1'b1} jk_state_t
  - helper function for popcount
- Sub-module jk_fsm_chan holds one channel: state, dwell counter, rise/fall, optional stats counter.
- Top generates NUM_CH instances, the popcount and the stats read mux.

Test Plan:
- Reset/classic (NUM_CH=4, MIN_DWELL=0): areset pulse mid-cycle -> out=0000 and on_count=0 before the next clk. Then j=0001 for 1 cycle -> out=0001 and rise=0001 next cycle. Then k=0001 -> out=0000 and fall=0001.
- Both j and k high, ch0 starting OFF: with j=k=1111 held 4 cycles and TOGGLE_MODE=0 -> out=1111 then 0000 alternating each cycle. TOGGLE_MODE=1 with the same stimulus -> same alternation.
- Dwell (MIN_DWELL=3): j[0]=1 at cycle 0 -> ON at cycle 1. k[0]=1 held from cycle 1 -> OFF no earlier than cycle 5. A k pulse only at cycle 2 -> stays ON.
- Freeze: en=0 for 5 cycles with random j/k -> out, dwell and stats unchanged, rise=fall=0. en=1 -> resumes with the residual dwell.
- Async reset mid-dwell (MIN_DWELL=5, ch2 ON) -> immediate OFF. j[2]=1 next cycle -> ON after 1 cycle (no dwell block).
- JK_FSM_BANK_STATS_EN, STAT_W=2: 5 OFF->ON transitions on ch1 -> stat_cnt (sel=1) = 3, saturated. stat_clr with a same-cycle rise -> 0. stat_sel=7 -> 0.
